// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the six-plane VRAM between VDP fetch and CPU window.
// VDP fetches win; a grant streak counter bounds how long the CPU waits.
module vram_arbiter #(
  parameter logic [15:0] WIN_BASE   = 16'hEC00,
  parameter logic [15:0] WIN_LAST   = 16'hFFFF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_req,
  input  logic [12:0] vdp_addr,
  output logic        vdp_valid,
  output logic [7:0]  pl_fg1,
  output logic [7:0]  pl_fg2,
  output logic [7:0]  pl_fg3,
  output logic [7:0]  pl_bg1,
  output logic [7:0]  pl_bg2,
  output logic [7:0]  pl_bg3,
  output logic        vdp_overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic [5:0]  wr_mask,
  input  logic [2:0]  rd_sel,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic [5:0]  ram_we,
  input  logic [47:0] ram_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE, V1, V2, CW, C1, C2, C3
  } state_t;

  state_t state, state_d;

  logic          vdp_pend;
  logic [12:0]   vdp_lat;
  logic          armed;
  logic [SW-1:0] streak;
  logic          c_inwin;
  logic [12:0]   c_off;
  logic [2:0]    c_sel;

  logic        cpu_valid;
  logic        starve;
  logic        grant_v;
  logic        grant_c;
  logic        in_lo;
  logic        in_hi;
  logic        in_win;
  logic        ack_set;
  logic [12:0] cpu_off;
  logic [7:0]  rd_byte;

  assign cpu_valid = cpu_req & armed;
  assign starve    = cpu_valid && (streak == SMAX);
  assign grant_v   = (state == IDLE) && vdp_pend && !starve;
  assign grant_c   = (state == IDLE) && cpu_valid && !grant_v;
  assign ack_set   = (state == CW) || (state == C3);
  assign cpu_off   = cpu_addr[12:0] - WIN_BASE[12:0];
  assign in_lo     = cpu_addr >= WIN_BASE;
  assign in_win    = in_lo && in_hi;

  // A window ending at the top of memory needs no upper compare.
  if (WIN_LAST == 16'hFFFF) begin : g_top
    assign in_hi = 1'b1;
  end else begin : g_lim
    assign in_hi = cpu_addr <= WIN_LAST;
  end

  always_comb begin
    rd_byte = 8'hFF;
    unique case (c_sel)
      3'd1:    rd_byte = ram_q[7:0];
      3'd2:    rd_byte = ram_q[15:8];
      3'd3:    rd_byte = ram_q[23:16];
      3'd4:    rd_byte = ram_q[31:24];
      3'd5:    rd_byte = ram_q[39:32];
      3'd6:    rd_byte = ram_q[47:40];
      default: rd_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (grant_v)      state_d = V1;
        else if (grant_c) state_d = cpu_we ? CW : C1;
      end
      V1:      state_d = V2;
      V2:      state_d = IDLE;
      CW:      state_d = IDLE;
      C1:      state_d = C2;
      C2:      state_d = C3;
      C3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture: a new strobe beats a same-cycle grant clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vdp_pend    <= 1'b0;
      vdp_lat     <= '0;
      vdp_overrun <= 1'b0;
      armed       <= 1'b0;
    end else begin
      if (vdp_req) begin
        vdp_pend <= 1'b1;
        vdp_lat  <= vdp_addr;
        if (vdp_pend) vdp_overrun <= 1'b1;
      end else if (grant_v) begin
        vdp_pend <= 1'b0;
      end
      if (ack_set)       armed <= 1'b0;
      else if (!cpu_req) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= '0;
      streak    <= '0;
      c_inwin   <= 1'b0;
      c_off     <= '0;
      c_sel     <= '0;
      cpu_dout  <= '0;
      cpu_ack   <= 1'b0;
      vdp_valid <= 1'b0;
      pl_fg1    <= '0;
      pl_fg2    <= '0;
      pl_fg3    <= '0;
      pl_bg1    <= '0;
      pl_bg2    <= '0;
      pl_bg3    <= '0;
    end else begin
      vdp_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (grant_v) begin
        ram_addr <= vdp_lat;
        if (cpu_valid && streak != SMAX)
          streak <= streak + SW'(1);
      end
      if (grant_c) begin
        streak  <= '0;
        c_sel   <= rd_sel;
        c_inwin <= in_win;
        c_off   <= cpu_off;
        if (cpu_we && in_win) begin
          ram_addr <= cpu_off;
          ram_din  <= cpu_din;
          ram_we   <= wr_mask;
        end
      end
      unique case (state)
        V2: begin
          pl_fg1    <= ram_q[7:0];
          pl_fg2    <= ram_q[15:8];
          pl_fg3    <= ram_q[23:16];
          pl_bg1    <= ram_q[31:24];
          pl_bg2    <= ram_q[39:32];
          pl_bg3    <= ram_q[47:40];
          vdp_valid <= 1'b1;
        end
        CW: begin
          ram_we  <= '0;
          cpu_ack <= 1'b1;
        end
        C1: begin
          if (c_inwin) ram_addr <= c_off;
        end
        C3: begin
          cpu_dout <= c_inwin ? rd_byte : 8'hFF;
          cpu_ack  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized bench with a plane-array VRAM reference.
// Drives VDP strobes and CPU transactions, checks data and timing.
module tb_vram_arbiter;

  localparam logic [15:0] WIN_BASE = 16'hEC00;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdp_req = 1'b0;
  logic [12:0] vdp_addr = '0;
  logic        vdp_valid;
  logic [7:0]  pl_fg1, pl_fg2, pl_fg3;
  logic [7:0]  pl_bg1, pl_bg2, pl_bg3;
  logic        vdp_overrun;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [5:0]  wr_mask = '0;
  logic [2:0]  rd_sel = '0;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic [5:0]  ram_we;
  logic [47:0] ram_q = '0;

  int errors = 0;
  int checks = 0;

  logic [12:0] we_addr;
  logic [7:0]  we_din;
  logic [5:0]  we_mask;

  vram_arbiter #(
    .WIN_BASE(16'hEC00),
    .WIN_LAST(16'hFFFF),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vdp_req(vdp_req), .vdp_addr(vdp_addr),
    .vdp_valid(vdp_valid),
    .pl_fg1(pl_fg1), .pl_fg2(pl_fg2), .pl_fg3(pl_fg3),
    .pl_bg1(pl_bg1), .pl_bg2(pl_bg2), .pl_bg3(pl_bg3),
    .vdp_overrun(vdp_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .wr_mask(wr_mask), .rd_sel(rd_sel),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int p, int a);
    if (a == 'h0EC0) return 8'h0F - 8'(p);
    return 8'((a * 7) ^ (p * 37) ^ (a >> 5));
  endfunction

  // VRAM: six planes, synchronous read, per-plane write enable.
  bit mem_init = 1'b0;
  logic [7:0] ram_mem [6][8192];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int p = 0; p < 6; p++)
        for (int a = 0; a < 8192; a++)
          ram_mem[p][a] <= pat(p, a);
      mem_init <= 1'b1;
    end else begin
      for (int p = 0; p < 6; p++)
        if (ram_we[p]) ram_mem[p][ram_addr] <= ram_din;
    end
    ram_q <= {ram_mem[5][ram_addr], ram_mem[4][ram_addr],
              ram_mem[3][ram_addr], ram_mem[2][ram_addr],
              ram_mem[1][ram_addr], ram_mem[0][ram_addr]};
  end

  logic [7:0] ref_mem [6][8192];

  function automatic logic [47:0] ref_word(int a);
    return {ref_mem[5][a], ref_mem[4][a], ref_mem[3][a],
            ref_mem[2][a], ref_mem[1][a], ref_mem[0][a]};
  endfunction

  function automatic logic [47:0] pl_word();
    return {pl_bg3, pl_bg2, pl_bg1, pl_fg3, pl_fg2, pl_fg1};
  endfunction

  function automatic logic [7:0] exp_read(logic [15:0] a,
                                          logic [2:0] s);
    int off;
    if (a < WIN_BASE) return 8'hFF;
    if (s == 3'd0 || s == 3'd7) return 8'hFF;
    off = int'(a - WIN_BASE);
    return ref_mem[int'(s) - 1][off];
  endfunction

  task automatic ref_write(logic [15:0] a, logic [7:0] d,
                           logic [5:0] m);
    int off;
    if (a < WIN_BASE) return;
    off = int'(a - WIN_BASE);
    for (int p = 0; p < 6; p++)
      if (m[p]) ref_mem[p][off] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_txn(input logic we, input logic [15:0] a,
                         input logic [7:0] d, input logic [5:0] m,
                         input logic [2:0] s, input int hold,
                         output logic acked, output logic [7:0] dout,
                         output int lat, output int wes,
                         output int extra);
    cpu_we = we; cpu_addr = a; cpu_din = d;
    wr_mask = m; rd_sel = s; cpu_req = 1'b1;
    acked = 1'b0; dout = '0; lat = 0; wes = 0; extra = 0;
    while (!acked && lat < 40) begin
      tick();
      lat++;
      if (ram_we != '0) begin
        wes++;
        we_addr = ram_addr; we_din = ram_din; we_mask = ram_we;
      end
      if (cpu_ack) begin
        acked = 1'b1;
        dout = cpu_dout;
      end
      if (lat == 1) begin
        wr_mask = 6'($urandom);
        rd_sel = 3'($urandom);
      end
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (cpu_ack) extra++;
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic vdp_fetch(input logic [12:0] a, output int lat,
                           output logic [12:0] first_addr);
    vdp_addr = a; vdp_req = 1'b1;
    tick();
    vdp_req = 1'b0;
    lat = 0;
    first_addr = '0;
    while (lat < 10) begin
      tick();
      lat++;
      if (lat == 1) first_addr = ram_addr;
      if (vdp_valid) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if (ram_we !== 6'd0) begin
      errors++;
      $display("FAIL reset_ram_we got=%b want=000000", ram_we);
    end
    checks++;
    if (cpu_ack !== 1'b0 || vdp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses ack=%b valid=%b want=0 0",
               cpu_ack, vdp_valid);
    end
    checks++;
    if (vdp_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got=%b want=0", vdp_overrun);
    end
    checks++;
    if ({ram_addr, ram_din} !== 21'd0) begin
      errors++;
      $display("FAIL reset_ram_bus got=%h want=0", {ram_addr, ram_din});
    end
    checks++;
    if (cpu_dout !== 8'd0) begin
      errors++;
      $display("FAIL reset_cpu_dout got=%h want=00", cpu_dout);
    end
    checks++;
    if (pl_word() !== 48'd0) begin
      errors++;
      $display("FAIL reset_planes got=%h want=0", pl_word());
    end
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_vdp_fetch();
    int lat;
    logic [12:0] fa;
    logic [12:0] a;
    vdp_fetch(13'h0EC0, lat, fa);
    checks++;
    if (fa !== 13'h0EC0) begin
      errors++;
      $display("FAIL vdp_ram_addr got=%h want=0ec0", fa);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL vdp_latency got=%0d want=3", lat);
    end
    checks++;
    if (pl_fg1 !== 8'h0F || pl_bg3 !== 8'h0A) begin
      errors++;
      $display("FAIL vdp_fg1_bg3 got=%h %h want=0f 0a", pl_fg1, pl_bg3);
    end
    checks++;
    if (pl_word() !== 48'h0A0B0C0D0E0F) begin
      errors++;
      $display("FAIL vdp_planes got=%h want=0a0b0c0d0e0f", pl_word());
    end
    tick();
    checks++;
    if (vdp_valid !== 1'b0) begin
      errors++;
      $display("FAIL vdp_valid_pulse got=%b want=0", vdp_valid);
    end
    for (int i = 0; i < 6; i++) begin
      a = 13'($urandom);
      vdp_fetch(a, lat, fa);
      checks++;
      if (lat !== 3 || pl_word() !== ref_word(int'(a))) begin
        errors++;
        $display("FAIL vdp_rand a=%h lat=%0d got=%h want=%h",
                 a, lat, pl_word(), ref_word(int'(a)));
      end
      tick();
    end
  endtask

  task automatic test_cpu_write();
    logic ok;
    logic [7:0] d;
    int lat, wes, ex;
    cpu_txn(1'b1, 16'hEC05, 8'h5A, 6'b000101, 3'd0, 0,
            ok, d, lat, wes, ex);
    ref_write(16'hEC05, 8'h5A, 6'b000101);
    checks++;
    if (!ok || lat !== 2) begin
      errors++;
      $display("FAIL wr_ack ack=%b lat=%0d want=1 2", ok, lat);
    end
    checks++;
    if (wes !== 1) begin
      errors++;
      $display("FAIL wr_we_cycles got=%0d want=1", wes);
    end
    checks++;
    if (we_addr !== 13'd5 || we_mask !== 6'b000101 || we_din !== 8'h5A) begin
      errors++;
      $display("FAIL wr_bus addr=%h we=%b din=%h want=0005 000101 5a",
               we_addr, we_mask, we_din);
    end
    cpu_txn(1'b0, 16'hEC05, 8'h00, 6'h00, 3'd3, 0, ok, d, lat, wes, ex);
    checks++;
    if (!ok || lat > 4 || d !== 8'h5A) begin
      errors++;
      $display("FAIL rd_fg3 ack=%b lat=%0d got=%h want=5a", ok, lat, d);
    end
    cpu_txn(1'b0, 16'hEC05, 8'h00, 6'h00, 3'd7, 0, ok, d, lat, wes, ex);
    checks++;
    if (!ok || d !== 8'hFF) begin
      errors++;
      $display("FAIL rd_sel7 ack=%b got=%h want=ff", ok, d);
    end
    cpu_txn(1'b0, 16'hEC05, 8'h00, 6'h00, 3'd2, 0, ok, d, lat, wes, ex);
    checks++;
    if (!ok || d !== exp_read(16'hEC05, 3'd2)) begin
      errors++;
      $display("FAIL rd_fg2_kept got=%h want=%h", d,
               exp_read(16'hEC05, 3'd2));
    end
  endtask

  task automatic test_out_of_window();
    logic ok;
    logic [7:0] d;
    int lat, wes, ex;
    cpu_txn(1'b0, 16'h1234, 8'h00, 6'h00, 3'd1, 6, ok, d, lat, wes, ex);
    checks++;
    if (!ok || lat > 4 || wes !== 0 || d !== 8'hFF) begin
      errors++;
      $display("FAIL oow_read ack=%b lat=%0d we=%0d got=%h want=ff",
               ok, lat, wes, d);
    end
    checks++;
    if (ex !== 0) begin
      errors++;
      $display("FAIL held_req_reack got=%0d want=0", ex);
    end
    cpu_txn(1'b1, 16'h8000, 8'hA5, 6'h3F, 3'd0, 0, ok, d, lat, wes, ex);
    checks++;
    if (!ok || lat !== 2 || wes !== 0) begin
      errors++;
      $display("FAIL oow_write ack=%b lat=%0d we=%0d want=1 2 0",
               ok, lat, wes);
    end
  endtask

  task automatic test_starvation();
    logic acked;
    logic [7:0] d;
    logic [15:0] a;
    logic [2:0] s;
    int nv, cack;
    for (int r = 0; r < 2; r++) begin
      a = WIN_BASE + 16'($urandom_range(0, 'h13FF));
      s = 3'($urandom_range(1, 6));
      vdp_addr = 13'($urandom); vdp_req = 1'b1; cpu_req = 1'b0;
      tick();
      vdp_req = 1'b0;
      cpu_we = 1'b0; cpu_addr = a; rd_sel = s; cpu_req = 1'b1;
      nv = 0; acked = 1'b0; cack = 0; d = '0;
      for (int c = 1; c <= 40 && !acked; c++) begin
        tick();
        if (cpu_ack) begin
          acked = 1'b1; cack = c; d = cpu_dout;
          cpu_req = 1'b0; vdp_req = 1'b0;
        end else begin
          if (vdp_valid) nv++;
          vdp_req = (c % 3 == 2);
          vdp_addr = 13'($urandom);
        end
      end
      vdp_req = 1'b0; cpu_req = 1'b0;
      repeat (8) tick();
      checks++;
      if (!acked || nv !== STARVE_MAX) begin
        errors++;
        $display("FAIL starve_grants round=%0d ack=%b got=%0d want=%0d",
                 r, acked, nv, STARVE_MAX);
      end
      checks++;
      if (cack > 1 + STARVE_MAX * 3 + 3 + 3 || d !== exp_read(a, s)) begin
        errors++;
        $display("FAIL starve_cpu round=%0d at=%0d got=%h want=%h",
                 r, cack, d, exp_read(a, s));
      end
    end
  endtask

  task automatic test_overrun_reset();
    logic got_ack;
    logic ok;
    logic [7:0] d;
    logic [47:0] cap;
    int nv, lat, wes, ex;
    logic [12:0] fa;
    cpu_req = 1'b0; vdp_req = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (vdp_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%b want=0", vdp_overrun);
    end
    cpu_we = 1'b0; cpu_addr = WIN_BASE + 16'h0040; rd_sel = 3'd1;
    cpu_req = 1'b1;
    tick();
    vdp_req = 1'b1; vdp_addr = 13'h0100;
    tick();
    vdp_addr = 13'h0200;
    tick();
    vdp_req = 1'b0;
    got_ack = 1'b0; nv = 0; cap = '0; d = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_ack) begin
        got_ack = 1'b1; d = cpu_dout; cpu_req = 1'b0;
      end
      if (vdp_valid) begin
        nv++; cap = pl_word();
      end
    end
    checks++;
    if (!got_ack || d !== exp_read(WIN_BASE + 16'h0040, 3'd1)) begin
      errors++;
      $display("FAIL busy_read ack=%b got=%h", got_ack, d);
    end
    checks++;
    if (vdp_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b want=1", vdp_overrun);
    end
    checks++;
    if (nv !== 1 || cap !== ref_word('h200)) begin
      errors++;
      $display("FAIL overrun_fetch n=%0d got=%h want=%h",
               nv, cap, ref_word('h200));
    end
    cpu_we = 1'b1; cpu_addr = WIN_BASE + 16'h0077; cpu_din = 8'hC3;
    wr_mask = 6'h3F; cpu_req = 1'b1;
    tick();
    checks++;
    if (ram_we !== 6'h3F) begin
      errors++;
      $display("FAIL cw_we got=%b want=111111", ram_we);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 6'd0 || vdp_overrun !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset we=%b ovr=%b ack=%b want=0 0 0",
               ram_we, vdp_overrun, cpu_ack);
    end
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    vdp_fetch(13'h0333, lat, fa);
    checks++;
    if (lat !== 3 || pl_word() !== ref_word('h333)) begin
      errors++;
      $display("FAIL post_reset_idle lat=%0d got=%h", lat, pl_word());
    end
    tick();
    cpu_txn(1'b0, WIN_BASE + 16'h0077, 8'h00, 6'h00, 3'd4, 0,
            ok, d, lat, wes, ex);
    checks++;
    if (!ok || d !== exp_read(WIN_BASE + 16'h0077, 3'd4)) begin
      errors++;
      $display("FAIL aborted_write got=%h want=%h", d,
               exp_read(WIN_BASE + 16'h0077, 3'd4));
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [7:0] d, din;
    logic [5:0] m;
    logic [2:0] s;
    logic [15:0] a;
    logic [12:0] va, fa;
    logic inwin;
    int op, lat, wes, ex;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      inwin = ($urandom_range(0, 4) != 0);
      a = inwin ? WIN_BASE + 16'($urandom_range(0, 'h13FF))
                : 16'($urandom_range(0, 'hEBFF));
      if (op == 0) begin
        din = 8'($urandom); m = 6'($urandom);
        cpu_txn(1'b1, a, din, m, 3'd0, 0, ok, d, lat, wes, ex);
        ref_write(a, din, m);
        checks++;
        if (!ok || lat !== 2 || wes !== ((inwin && m != 0) ? 1 : 0)) begin
          errors++;
          $display("FAIL rand_write a=%h ack=%b lat=%0d we=%0d",
                   a, ok, lat, wes);
        end
      end else if (op == 1) begin
        s = 3'($urandom);
        cpu_txn(1'b0, a, 8'h00, 6'h00, s, 0, ok, d, lat, wes, ex);
        checks++;
        if (!ok || lat > 4 || wes !== 0 || d !== exp_read(a, s)) begin
          errors++;
          $display("FAIL rand_read a=%h sel=%0d got=%h want=%h",
                   a, s, d, exp_read(a, s));
        end
      end else begin
        va = 13'($urandom);
        vdp_fetch(va, lat, fa);
        checks++;
        if (lat !== 3 || pl_word() !== ref_word(int'(va))) begin
          errors++;
          $display("FAIL rand_vdp a=%h lat=%0d got=%h want=%h",
                   va, lat, pl_word(), ref_word(int'(va)));
        end
        tick();
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 6; p++)
      for (int a = 0; a < 8192; a++)
        ref_mem[p][a] = pat(p, a);
    test_reset();
    test_vdp_fetch();
    test_cpu_write();
    test_out_of_window();
    test_starvation();
    test_overrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the six-plane RX-78 VRAM (fg1..fg3, bg1..bg3; one common address, one write-enable per plane) between the VDP pixel fetch and CPU memory accesses to window 0xEC00–0xFFFF.
- VDP fetches have priority. A starvation counter bounds CPU wait.
- Applies the CPU plane write mask and read plane select. Latches the six plane bytes for the VDP.

Parameters:
- WIN_BASE, 16'hEC00, first CPU address of the VRAM window.
- WIN_LAST, 16'hFFFF, last CPU address of the VRAM window.
- STARVE_MAX, 4, consecutive VDP grants allowed while the CPU is pending before the CPU wins.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vdp_req  in  1  one-cycle fetch strobe from the VDP.
- vdp_addr  in  13  VRAM fetch address.
- vdp_valid  out  1  one-cycle pulse; plane outputs updated.
- pl_fg1, pl_fg2, pl_fg3, pl_bg1, pl_bg2, pl_bg3  out  8 each  latched plane bytes for the VDP.
- vdp_overrun  out  1  sticky flag: a VDP fetch was dropped.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- wr_mask  in  6  plane write enables {bg3,bg2,bg1,fg3,fg2,fg1}.
- rd_sel  in  3  read plane: 1..3 = fg1..fg3, 4..6 = bg1..bg3.
- ram_addr  out  13  VRAM address.
- ram_din  out  8  VRAM write data.
- ram_we  out  6  per-plane write enables, same bit order as wr_mask.
- ram_q  in  48  VRAM read data {bg3,bg2,bg1,fg3,fg2,fg1}. Synchronous read: valid the cycle after ram_addr has been sampled.

Behaviour:

Reset (asynchronous):
- State IDLE.
- All outputs 0; ram_we forced to 0 immediately, including mid-operation.
- vdp_pend, armed, streak and vdp_overrun are cleared.

VDP request latch:
- vdp_req high sets vdp_pend and captures vdp_addr.
- If vdp_pend is already set, the new address overwrites the old one and vdp_overrun is set (sticky).
- If a set and a clear of vdp_pend happen in the same cycle, the set wins.

CPU request validity:
- The armed flag is set when cpu_req is sampled low and cleared on cpu_ack.
- A CPU request is valid when cpu_req = 1 and armed = 1.

States:
- IDLE:
  - If vdp_pend and NOT (cpu valid and streak == STARVE_MAX): ram_addr <= latched address; clear vdp_pend; if cpu valid then streak++ (saturating); go to V1.
  - Else if cpu valid: streak <= 0; go to CW (write) or C1 (read).
  - Else stay in IDLE.
- V1: go to V2. RAM samples the address in this cycle.
- V2: pl_* <= ram_q; vdp_valid <= 1; go to IDLE.
- CW (write, in-window): ram_addr <= cpu_addr − WIN_BASE (13 LSBs); ram_din <= cpu_din; ram_we <= wr_mask for one cycle; then cpu_ack <= 1 and go to IDLE.
- CW (write, out-of-window): no RAM write; cpu_ack the next cycle.
- C1: ram_addr <= offset; go to C2.
- C2: wait for ram_q; go to C3.
- C3: cpu_dout <= byte selected by rd_sel; cpu_ack <= 1; go to IDLE.
  - rd_sel of 0 or 7 returns 8'hFF.
  - Out-of-window reads return 8'hFF.

Timing:
- With the arbiter idle, vdp_valid is asserted 3 cycles after the edge that samples vdp_req.
- A VDP fetch occupies 3 cycles.
- Worst-case CPU wait is STARVE_MAX × 3 + 3 cycles once the request is valid.
- wr_mask and rd_sel are sampled at grant time. Changes during a transaction have no effect on it.
- ram_we is 0 in every state other than the CW write cycle.

Test Plan:
1. Reset, then vdp_req with vdp_addr = 0x0EC0 and ram_q = 48'h0A0B0C0D0E0F → ram_addr = 0x0EC0; vdp_valid 3 cycles later; pl_fg1 = 0x0F, pl_bg3 = 0x0A.
2. CPU write to 0xEC05, din 0x5A, wr_mask 6'b000101 → one cycle with ram_addr = 5 and ram_we = 000101; cpu_ack one cycle later. A read back with rd_sel = 3 returns 0x5A (RAM model); rd_sel = 7 returns 0xFF.
3. CPU read of 0x1234 (outside window) → no ram_we; cpu_dout = 0xFF; cpu_ack within 4 cycles. Holding cpu_req high after ack produces no second ack until cpu_req has gone low.
4. vdp_req every 3 cycles while a CPU read is pending, STARVE_MAX = 4 → exactly 4 VDP grants, then the CPU is granted; streak resets to 0.
5. Two vdp_req strobes in consecutive cycles while the arbiter is busy with a CPU read → vdp_overrun = 1; only the second address is fetched. Assert reset_n low mid-CW → ram_we drops to 0 immediately, state IDLE, vdp_overrun = 0.
